// File: rtl/rgb_rx_pkg.sv
// Shared definitions for the RGB packet receiver: FSM encodings, check modes
// and the running check-byte update.
package rgb_rx_pkg;

  localparam int BYTE_W = 8;

  localparam int CHECK_NONE = 0;
  localparam int CHECK_XOR  = 1;
  localparam int CHECK_SUM  = 2;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    START   = 4'd1,
    CMD     = 4'd2,
    LEN     = 4'd3,
    PAYLOAD = 4'd4,
    CHECK   = 4'd5,
    STOP    = 4'd6,
    DONE    = 4'd7,
    RESYNC  = 4'd8
  } rx_state_e;

  // Folds one received byte into the check accumulator; CHECK_NONE leaves it untouched.
  function automatic logic [BYTE_W-1:0] check_update(input logic [BYTE_W-1:0] acc,
                                                     input logic [BYTE_W-1:0] data,
                                                     input int                mode);
    case (mode)
      CHECK_XOR: check_update = acc ^ data;
      CHECK_SUM: check_update = acc + data;
      default:   check_update = acc;
    endcase
  endfunction

endpackage

// File: rtl/rx_bit_sampler.sv
// Front end of the receiver: 2-flop synchroniser on the RX pin and a baud counter
// that strobes half a bit after the start edge, then once per full bit period.
module rx_bit_sampler #(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_in_i,
  input  logic idle_i,
  input  logic run_i,
  output logic rx_s_o,
  output logic start_o,
  output logic sample_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             first_q;

  assign rx_s_o   = sync_q[1];
  assign start_o  = idle_i & ~sync_q[1];
  assign sample_o = run_i & (cnt_q == (first_q ? HALF_LAST : FULL_LAST));

  // The start edge re-arms the counter so the first strobe lands mid start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_in_i};
      if (start_o) begin
        cnt_q   <= '0;
        first_q <= 1'b1;
      end else if (sample_o) begin
        cnt_q   <= '0;
        first_q <= 1'b0;
      end else if (run_i) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_packet_rx_param.sv
// Serial RGB control-packet receiver: frame FSM, field assembly, check verification
// and shadow-registered packet outputs that only change on a good packet.
module rgb_packet_rx_param
  import rgb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int MAX_PAYLOAD  = 3,
  parameter int CHECK_MODE   = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx_in,
  output logic                            pkt_valid,
  output logic [BYTE_W-1:0]               pkt_cmd,
  output logic [BYTE_W-1:0]               pkt_len,
  output logic [BYTE_W*MAX_PAYLOAD-1:0]   pkt_payload,
  output logic [BYTE_W-1:0]               pkt_check,
  output logic                            err_check,
  output logic                            err_frame,
  output logic                            err_length,
  output logic                            busy,
  output logic [3:0]                      state_dbg
);

  localparam int PAY_W = BYTE_W * MAX_PAYLOAD;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  RS_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] MAX_LEN = BYTE_W'(MAX_PAYLOAD);

  rx_state_e         state_q, state_d;
  logic [2:0]        bit_q, bit_d;
  logic [4:0]        idx_q, idx_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [BYTE_W-1:0] cmd_q, cmd_d, len_q, len_d, check_q, check_d, acc_q, acc_d;
  logic [PAY_W-1:0]  payload_q, payload_d;
  logic [CNT_W-1:0]  rs_cnt_q, rs_cnt_d;

  logic              pkt_valid_q, pkt_valid_d;
  logic              err_check_q, err_check_d, err_frame_q, err_frame_d;
  logic              err_length_q, err_length_d;
  logic [BYTE_W-1:0] pkt_cmd_q, pkt_cmd_d, pkt_len_q, pkt_len_d, pkt_check_q, pkt_check_d;
  logic [PAY_W-1:0]  pkt_payload_q, pkt_payload_d;

  logic              rx_s, start, sample, run, byte_done;
  logic [BYTE_W-1:0] rx_byte;

  assign run       = (state_q != IDLE) && (state_q != DONE) && (state_q != RESYNC);
  assign rx_byte   = {rx_s, shift_q[BYTE_W-1:1]};
  assign byte_done = sample && (bit_q == 3'd7);

  rx_bit_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
    .clk      (clk),
    .reset    (reset),
    .rx_in_i  (rx_in),
    .idle_i   (state_q == IDLE),
    .run_i    (run),
    .rx_s_o   (rx_s),
    .start_o  (start),
    .sample_o (sample)
  );

  always_comb begin
    state_d       = state_q;
    bit_d         = bit_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    cmd_d         = cmd_q;
    len_d         = len_q;
    check_d       = check_q;
    acc_d         = acc_q;
    payload_d     = payload_q;
    rs_cnt_d      = rs_cnt_q;
    pkt_valid_d   = 1'b0;
    err_check_d   = 1'b0;
    err_frame_d   = 1'b0;
    err_length_d  = 1'b0;
    pkt_cmd_d     = pkt_cmd_q;
    pkt_len_d     = pkt_len_q;
    pkt_payload_d = pkt_payload_q;
    pkt_check_d   = pkt_check_q;

    if (sample && (state_q inside {CMD, LEN, PAYLOAD, CHECK})) begin
      shift_d = rx_byte;
      bit_d   = bit_q + 3'd1;
    end

    unique case (state_q)
      IDLE: if (start) begin
        state_d   = START;
        bit_d     = '0;
        idx_d     = '0;
        acc_d     = '0;
        payload_d = '0;
      end
      START: if (sample) begin
        if (!rx_s) state_d = CMD;
        else begin
          err_frame_d = 1'b1;
          state_d     = IDLE;
        end
      end
      CMD: if (byte_done) begin
        cmd_d   = rx_byte;
        acc_d   = check_update(acc_q, rx_byte, CHECK_MODE);
        state_d = LEN;
      end
      LEN: if (byte_done) begin
        len_d = rx_byte;
        acc_d = check_update(acc_q, rx_byte, CHECK_MODE);
        if (rx_byte == '0 || rx_byte > MAX_LEN) begin
          err_length_d = 1'b1;
          rs_cnt_d     = '0;
          state_d      = RESYNC;
        end else begin
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (byte_done) begin
        for (int i = 0; i < MAX_PAYLOAD; i++)
          if (idx_q == 5'(i)) payload_d[BYTE_W*i +: BYTE_W] = rx_byte;
        acc_d = check_update(acc_q, rx_byte, CHECK_MODE);
        idx_d = idx_q + 5'd1;
        if ({3'b000, idx_q} == len_q - 8'd1) state_d = CHECK;
      end
      CHECK: if (byte_done) begin
        check_d = rx_byte;
        state_d = STOP;
      end
      // Stop framing outranks the check; the packet outputs move only on success.
      STOP: if (sample) begin
        state_d = DONE;
        if (!rx_s) err_frame_d = 1'b1;
        else if (CHECK_MODE != CHECK_NONE && acc_q != check_q) err_check_d = 1'b1;
        else begin
          pkt_valid_d   = 1'b1;
          pkt_cmd_d     = cmd_q;
          pkt_len_d     = len_q;
          pkt_payload_d = payload_q;
          pkt_check_d   = check_q;
        end
      end
      DONE: state_d = IDLE;
      RESYNC: begin
        if (!rx_s) rs_cnt_d = '0;
        else if (rs_cnt_q == RS_LAST) state_d = IDLE;
        else rs_cnt_d = rs_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      cmd_q         <= '0;
      len_q         <= '0;
      check_q       <= '0;
      acc_q         <= '0;
      payload_q     <= '0;
      rs_cnt_q      <= '0;
      pkt_valid_q   <= 1'b0;
      err_check_q   <= 1'b0;
      err_frame_q   <= 1'b0;
      err_length_q  <= 1'b0;
      pkt_cmd_q     <= '0;
      pkt_len_q     <= '0;
      pkt_payload_q <= '0;
      pkt_check_q   <= '0;
    end else begin
      state_q       <= state_d;
      bit_q         <= bit_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      cmd_q         <= cmd_d;
      len_q         <= len_d;
      check_q       <= check_d;
      acc_q         <= acc_d;
      payload_q     <= payload_d;
      rs_cnt_q      <= rs_cnt_d;
      pkt_valid_q   <= pkt_valid_d;
      err_check_q   <= err_check_d;
      err_frame_q   <= err_frame_d;
      err_length_q  <= err_length_d;
      pkt_cmd_q     <= pkt_cmd_d;
      pkt_len_q     <= pkt_len_d;
      pkt_payload_q <= pkt_payload_d;
      pkt_check_q   <= pkt_check_d;
    end
  end

  assign pkt_valid   = pkt_valid_q;
  assign pkt_cmd     = pkt_cmd_q;
  assign pkt_len     = pkt_len_q;
  assign pkt_payload = pkt_payload_q;
  assign pkt_check   = pkt_check_q;
  assign err_check   = err_check_q;
  assign err_frame   = err_frame_q;
  assign err_length  = err_length_q;
  assign busy        = (state_q != IDLE);
  assign state_dbg   = state_q;

endmodule
